// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 INCR burst master: one local read or write command at a
// time, write data streamed in from wr_*, read data streamed out on rd_*.
module axi_burst_master #(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned AXI_ID     = 0
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_aresetn,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [31:0]           cmd_addr,
    input  logic [7:0]            cmd_len,

    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,

    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_last,
    input  logic                  rd_ready,

    output logic                  done,
    output logic [1:0]            resp,

    output logic [ID_WIDTH-1:0]   m_axi_awid,
    output logic [31:0]           m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,

    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,

    input  logic [ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,

    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [31:0]           m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam int unsigned SIZE_ENC   = $clog2(STRB_WIDTH);
    localparam logic [1:0]  BURST_INCR = 2'b01;
    localparam logic [1:0]  RESP_SLV   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WADDR,
        S_WDATA,
        S_WRESP,
        S_RADDR,
        S_RDATA
    } state_t;

    state_t      state_q, state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [7:0]  awlen_q, awlen_d;
    logic        awvalid_q, awvalid_d;
    logic [31:0] araddr_q, araddr_d;
    logic [7:0]  arlen_q, arlen_d;
    logic        arvalid_q, arvalid_d;
    logic        bready_q, bready_d;
    logic [7:0]  beat_q, beat_d;
    logic        done_q, done_d;
    logic [1:0]  resp_q, resp_d;

    logic        in_wdata;
    logic        in_rdata;
    logic        w_fire;
    logic        r_fire;

    // Response IDs are not checked: only one transaction is ever outstanding.
    logic        unused_ids;
    assign unused_ids = ^{m_axi_bid, m_axi_rid};

    // Data phases are pure pass-through so a beat moves every cycle both sides agree.
    assign in_wdata     = (state_q == S_WDATA);
    assign in_rdata     = (state_q == S_RDATA);
    assign m_axi_wvalid = in_wdata && wr_valid;
    assign wr_ready     = in_wdata && m_axi_wready;
    assign m_axi_wdata  = wr_data;
    assign m_axi_wstrb  = '1;
    assign m_axi_wlast  = in_wdata && (beat_q == awlen_q);
    assign rd_valid     = in_rdata && m_axi_rvalid;
    assign rd_data      = m_axi_rdata;
    assign rd_last      = in_rdata && m_axi_rlast;
    assign m_axi_rready = in_rdata && rd_ready;
    assign w_fire       = m_axi_wvalid && m_axi_wready;
    assign r_fire       = m_axi_rvalid && m_axi_rready;

    assign m_axi_awid    = ID_WIDTH'(AXI_ID);
    assign m_axi_awsize  = 3'(SIZE_ENC);
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_arid    = ID_WIDTH'(AXI_ID);
    assign m_axi_arsize  = 3'(SIZE_ENC);
    assign m_axi_arburst = BURST_INCR;

    assign cmd_ready     = cmd_ready_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = awlen_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_bready  = bready_q;
    assign done          = done_q;
    assign resp          = resp_q;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
            awaddr_q    <= '0;
            awlen_q     <= '0;
            awvalid_q   <= 1'b0;
            araddr_q    <= '0;
            arlen_q     <= '0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            beat_q      <= '0;
            done_q      <= 1'b0;
            resp_q      <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awaddr_q    <= awaddr_d;
            awlen_q     <= awlen_d;
            awvalid_q   <= awvalid_d;
            araddr_q    <= araddr_d;
            arlen_q     <= arlen_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            beat_q      <= beat_d;
            done_q      <= done_d;
            resp_q      <= resp_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        awaddr_d  = awaddr_q;
        awlen_d   = awlen_q;
        awvalid_d = awvalid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arvalid_d = arvalid_q;
        bready_d  = bready_q;
        beat_d    = beat_q;
        done_d    = 1'b0;
        resp_d    = resp_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    resp_d = '0;
                    beat_d = '0;
                    if (cmd_write) begin
                        awaddr_d  = cmd_addr;
                        awlen_d   = cmd_len;
                        awvalid_d = 1'b1;
                        state_d   = S_WADDR;
                    end else begin
                        araddr_d  = cmd_addr;
                        arlen_d   = cmd_len;
                        arvalid_d = 1'b1;
                        state_d   = S_RADDR;
                    end
                end
            end
            S_WADDR: begin
                if (m_axi_awready) begin
                    awvalid_d = 1'b0;
                    state_d   = S_WDATA;
                end
            end
            S_WDATA: begin
                if (w_fire) begin
                    beat_d = beat_q + 8'd1;
                    if (m_axi_wlast) begin
                        beat_d   = '0;
                        bready_d = 1'b1;
                        state_d  = S_WRESP;
                    end
                end
            end
            S_WRESP: begin
                if (m_axi_bvalid) begin
                    resp_d   = m_axi_bresp;
                    bready_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_RADDR: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = S_RDATA;
                end
            end
            S_RDATA: begin
                if (r_fire) begin
                    beat_d = beat_q + 8'd1;
                    if (m_axi_rresp > resp_q) begin
                        resp_d = m_axi_rresp;
                    end
                    if (m_axi_rlast) begin
                        // A burst whose length disagrees with the request is reported as SLVERR.
                        if (beat_q != arlen_q) begin
                            resp_d = RESP_SLV;
                        end
                        beat_d  = '0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == S_IDLE);
    end

endmodule
